// File: rtl/tdm_demux_rx_if.sv
// Bus bundle for the TDM receive block: serial link side in, channel word side out.
// The parity_err signal exists only when FRAME_PARITY_EN is defined.
interface tdm_demux_rx_if #(
    parameter int unsigned CHANNELS = 4
);
    logic                din;
    logic                din_valid;
    logic                frame_sync;
    logic [CHANNELS-1:0] ch_out;
    logic                frame_valid;
    logic                locked;
    logic                sync_err;
`ifdef FRAME_PARITY_EN
    logic                parity_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_out, frame_valid, locked, sync_err, parity_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output ch_out, frame_valid, locked, sync_err, parity_err
    );
`else
    modport master (
        output din, din_valid, frame_sync,
        input  ch_out, frame_valid, locked, sync_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output ch_out, frame_valid, locked, sync_err
    );
`endif
endinterface

// File: rtl/tdm_demux_rx.sv
// TDM link receiver: locks to frame_sync, steers serial bits into channel slots, publishes one word per frame.
// Optional FRAME_PARITY_EN adds an even-parity slot after the last channel and a parity_err pulse.
module tdm_demux_rx #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux_rx_if.slave  bus
);

`ifdef FRAME_PARITY_EN
    localparam int unsigned LAST_SLOT = CHANNELS;
`else
    localparam int unsigned LAST_SLOT = CHANNELS - 1;
`endif

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]          state_q,  state_n;
    logic [CNT_W-1:0]    cnt_q,    cnt_n;
    logic [CHANNELS-1:0] shadow_q, shadow_n;
    logic [CHANNELS-1:0] ch_out_q, ch_out_n;
    logic                frame_valid_q, frame_valid_n;
    logic                locked_q,      locked_n;
    logic                sync_err_q,    sync_err_n;
`ifdef FRAME_PARITY_EN
    logic                parity_err_q,  parity_err_n;
    logic                parity_ok_c;
`endif

    logic [CHANNELS-1:0] merged_c;
    logic [CHANNELS-1:0] first_c;
    logic                end_slot_c;

    // Shadow with the current bit written into the slot the counter points at
    always_comb begin
        merged_c = shadow_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (cnt_q == CNT_W'(i)) begin
                merged_c[i] = bus.din;
            end
        end
    end

    assign first_c    = {{(CHANNELS-1){1'b0}}, bus.din};
    assign end_slot_c = (cnt_q == CNT_W'(LAST_SLOT));
`ifdef FRAME_PARITY_EN
    assign parity_ok_c = ~(^shadow_q ^ bus.din);
`endif

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            cnt_q         <= '0;
            shadow_q      <= '0;
            ch_out_q      <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef FRAME_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            shadow_q      <= shadow_n;
            ch_out_q      <= ch_out_n;
            frame_valid_q <= frame_valid_n;
            locked_q      <= locked_n;
            sync_err_q    <= sync_err_n;
`ifdef FRAME_PARITY_EN
            parity_err_q  <= parity_err_n;
`endif
        end
    end

    // Next-state and next-output logic; idle cycles only clear the pulses
    always_comb begin
        state_n       = state_q;
        cnt_n         = cnt_q;
        shadow_n      = shadow_q;
        ch_out_n      = ch_out_q;
        frame_valid_n = 1'b0;
        sync_err_n    = 1'b0;
`ifdef FRAME_PARITY_EN
        parity_err_n  = 1'b0;
`endif

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        shadow_n = first_c;
                        cnt_n    = CNT_W'(1);
                        state_n  = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.frame_sync && (cnt_q != '0)) begin
                        // Early sync: drop the partial frame and restart on this bit
                        sync_err_n = 1'b1;
                        shadow_n   = first_c;
                        cnt_n      = CNT_W'(1);
                    end else if (!bus.frame_sync && (cnt_q == '0)) begin
                        sync_err_n = 1'b1;
                        state_n    = HUNT;
                    end else if (bus.frame_sync) begin
                        shadow_n = first_c;
                        cnt_n    = CNT_W'(1);
                    end else if (end_slot_c) begin
                        cnt_n = '0;
`ifdef FRAME_PARITY_EN
                        if (parity_ok_c) begin
                            ch_out_n      = shadow_q;
                            frame_valid_n = 1'b1;
                        end else begin
                            parity_err_n  = 1'b1;
                        end
`else
                        shadow_n      = merged_c;
                        ch_out_n      = merged_c;
                        frame_valid_n = 1'b1;
`endif
                    end else begin
                        shadow_n = merged_c;
                        cnt_n    = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = HUNT;
                    cnt_n   = '0;
                end
            endcase
        end

        locked_n = (state_n == LOCK);
    end

    assign bus.ch_out      = ch_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = sync_err_q;
`ifdef FRAME_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx: scoreboard of expected channel words popped on each frame_valid.
// Parity scenario is compiled in only when FRAME_PARITY_EN is defined.
module tb_tdm_demux_rx;
    localparam int unsigned CH = 4;
`ifdef FRAME_PARITY_EN
    localparam int unsigned SLOTS = CH + 1;
`else
    localparam int unsigned SLOTS = CH;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux_rx_if #(.CHANNELS(CH)) bus();

    tdm_demux_rx #(.CHANNELS(CH), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fv = -1;
    int fv_seen = 0;
    int frames_pushed = 0;
    bit b2b = 1'b0;
    logic [CH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every frame_valid pulse
    always @(negedge clk) begin
        check("excl", 32'(bus.frame_valid & bus.sync_err), 32'd0);
        if (bus.frame_valid) begin
            fv_seen++;
            if (exp_q.size() == 0) begin
                check("fv_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("ch_out_sb", 32'(bus.ch_out), 32'(exp_q.pop_front()));
            end
            if (b2b) begin
                if (last_fv >= 0) check("fv_spacing", 32'(cyc - last_fv), 32'(SLOTS));
                last_fv = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic put_bit(input logic b, input logic s);
        bus.din        = b;
        bus.din_valid  = 1'b1;
        bus.frame_sync = s;
        @(posedge clk);
        #1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [CH-1:0] w, input int gap,
                              input logic exp_serr, input logic bad_par);
        logic [CH-1:0] hold;
        for (int i = 0; i < int'(CH); i++) begin
`ifndef FRAME_PARITY_EN
            if (i == int'(CH) - 1) begin
                exp_q.push_back(w);
                frames_pushed++;
            end
`endif
            put_bit(w[i], i == 0);
            if (i == 0) begin
                check("locked_first", 32'(bus.locked), 32'd1);
                check("serr_first", 32'(bus.sync_err), 32'(exp_serr));
            end
            if (gap > 0 && i < int'(CH) - 1) begin
                hold = bus.ch_out;
                idle(gap);
                check("gap_hold", 32'(bus.ch_out), 32'(hold));
                check("gap_fv", 32'(bus.frame_valid), 32'd0);
            end
        end
`ifdef FRAME_PARITY_EN
        if (!bad_par) begin
            exp_q.push_back(w);
            frames_pushed++;
        end
        put_bit((^w) ^ bad_par, 1'b0);
`else
        if (bad_par) $display("note: parity corruption ignored without parity slot");
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        #2;
        check("rst_ch_out", 32'(bus.ch_out), 32'd0);
        check("rst_fv", 32'(bus.frame_valid), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_serr", 32'(bus.sync_err), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Reset and lock
        send_frame(4'b1101, 0, 1'b0, 1'b0);
        check("frame1", 32'(bus.ch_out), 32'hD);
        idle(2);
        put_bit(1'b0, 1'b1);
        put_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ch_out", 32'(bus.ch_out), 32'd0);
        check("arst_locked", 32'(bus.locked), 32'd0);
        check("arst_fv", 32'(bus.frame_valid), 32'd0);
        check("arst_serr", 32'(bus.sync_err), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        put_bit(1'b1, 1'b0);
        check("hunt_drop_locked", 32'(bus.locked), 32'd0);

        // Gapped stream
        send_frame(4'b0110, 3, 1'b0, 1'b0);
        check("gapped", 32'(bus.ch_out), 32'h6);
        idle(2);

        // Early sync
        put_bit(1'b1, 1'b1);
        put_bit(1'b1, 1'b0);
        send_frame(4'b0100, 0, 1'b1, 1'b0);
        check("early_sync", 32'(bus.ch_out), 32'h4);
        idle(2);

        // Missing sync after a good frame
        put_bit(1'b1, 1'b0);
        check("miss_serr", 32'(bus.sync_err), 32'd1);
        check("miss_locked", 32'(bus.locked), 32'd0);
        for (int k = 0; k < 3; k++) begin
            put_bit(1'b1, 1'b0);
            check("miss_ignored_serr", 32'(bus.sync_err), 32'd0);
            check("miss_ignored_locked", 32'(bus.locked), 32'd0);
        end
        check("miss_hold", 32'(bus.ch_out), 32'h4);
        idle(2);

        // Back-to-back frames
        b2b = 1'b1;
        send_frame(4'b1010, 0, 1'b0, 1'b0);
        check("b2b_a", 32'(bus.ch_out), 32'hA);
        send_frame(4'b0101, 0, 1'b0, 1'b0);
        check("b2b_5", 32'(bus.ch_out), 32'h5);
        send_frame(4'b1111, 0, 1'b0, 1'b0);
        check("b2b_f", 32'(bus.ch_out), 32'hF);
        idle(2);
        b2b = 1'b0;

`ifdef FRAME_PARITY_EN
        send_frame(4'b0011, 0, 1'b0, 1'b0);
        check("par_ok", 32'(bus.ch_out), 32'h3);
        check("par_ok_perr", 32'(bus.parity_err), 32'd0);
        idle(2);
        send_frame(4'b0001, 0, 1'b0, 1'b1);
        check("par_bad_perr", 32'(bus.parity_err), 32'd1);
        check("par_bad_fv", 32'(bus.frame_valid), 32'd0);
        check("par_bad_hold", 32'(bus.ch_out), 32'h3);
        check("par_bad_locked", 32'(bus.locked), 32'd1);
        idle(1);
        check("par_perr_clear", 32'(bus.parity_err), 32'd0);
`endif

        idle(3);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("fv_count", 32'(fv_seen), 32'(frames_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of the team's 1-bit time-division link. The transmit side multiplexes CHANNELS single-bit sources round-robin onto one line; this block reverses that.
- Functions: locks to the frame-sync marker, steers each received bit to its channel slot, and publishes a registered CHANNELS-bit word once per complete frame.
- Sits between the serial link pins (or serializer loopback) and the parallel channel consumers.

Parameters:
- CHANNELS, 4, number of time slots per frame. Legal range 2..16.
- CNT_W, 4, slot counter width. Must satisfy 2^CNT_W >= CHANNELS+1.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial TDM data bit.
- din_valid  input  1  din and frame_sync are sampled only when this is high.
- frame_sync  input  1  qualified with din_valid. Marks the bit as slot 0 of a frame.
- ch_out  output  CHANNELS  last complete frame. Bit i = slot i.
- frame_valid  output  1  one-cycle pulse when ch_out updates.
- locked  output  1  high while in LOCK state.
- sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset is asynchronous on rst_n low. It drives ch_out=0, frame_valid=0, locked=0, sync_err=0, slot counter=0, shadow register=0, state=HUNT. Reset released mid-frame restarts in HUNT, and any partial frame is discarded.
- All other activity occurs on the rising edge of clk. Cycles with din_valid=0 change nothing except clearing the pulses; the counter holds.
- HUNT state:
  - din_valid & frame_sync: shadow[0]<=din, cnt<=1, go to LOCK.
  - Any other valid bit is dropped.
- LOCK state, for each valid bit:
  - frame_sync=1 & cnt!=0 (early sync): pulse sync_err. Discard the partial shadow. Take din as slot 0 (shadow[0]<=din, cnt<=1). Stay in LOCK.
  - frame_sync=0 & cnt==0 (missing sync): pulse sync_err, drop the bit, go to HUNT, locked<=0.
  - frame_sync=1 & cnt==0: shadow[0]<=din, cnt<=1.
  - Otherwise: shadow[cnt]<=din, cnt<=cnt+1.
- End of frame:
  - The end-of-frame slot is CHANNELS-1. With FRAME_PARITY_EN it is the parity slot CHANNELS instead.
  - When the bit for that slot is accepted, ch_out<={din merged into shadow} on the same edge and frame_valid is high for exactly the following cycle.
  - cnt wraps to 0, so the next valid bit must carry frame_sync.
- Latency: ch_out is visible 1 clk after the edge that samples the last channel bit.
- ch_out holds between frames. It is never partially updated.
- locked=1 exactly while state==LOCK.
- sync_err and frame_valid are mutually exclusive in any cycle.

Optional Feature:
- Macro: FRAME_PARITY_EN.
- Defined:
  - Each frame carries one extra slot after slot CHANNELS-1, holding even parity over the channel bits.
  - On the parity bit:
    - XOR of channels and the parity bit equals 0: update ch_out and pulse frame_valid.
    - Otherwise: ch_out holds, frame_valid stays 0, and output port parity_err (1 bit, reset 0) pulses for one cycle.
  - Lock is kept in both cases.
  - The CNT_W constraint covers CHANNELS+1 slots.
- Undefined: no parity slot, no parity_err port, and the frame ends at slot CHANNELS-1.

Test Plan:
All scenarios use CHANNELS=4, macro undefined except in the parity scenario.
- Reset and lock: assert rst_n=0 mid-stream -> all outputs 0 immediately (async). Release, then send valid frame bits 1,0,1,1 with sync on the first bit -> locked=1 after the first bit; ch_out=4'b1101 and frame_valid=1 for one cycle, the cycle after the 4th bit.
- Gapped stream: same frame 0,1,1,0 with din_valid low for 3 cycles between each bit -> ch_out=4'b0110 and a single frame_valid pulse. No change during the gaps.
- Early sync: send 1,1 then sync with bits 0,0,1,0 -> sync_err pulse on the early sync bit; ch_out=4'b0100. Old partial data never appears.
- Missing sync: after a good frame, send a valid bit without frame_sync -> sync_err pulse, locked=0. The next 3 non-sync bits are ignored, and ch_out keeps its prior value.
- Back-to-back: three consecutive frames 0xA, 0x5, 0xF with din_valid held high -> frame_valid every 4th cycle with ch_out 4'b1010, 4'b0101, 4'b1111 in sequence.
- Parity (FRAME_PARITY_EN defined):
  - Frame 1,1,0,0 with parity 0 -> ch_out=4'b0011 and frame_valid.
  - Frame 1,0,0,0 with parity 0 -> parity_err pulse, ch_out stays 4'b0011.
